// File: rtl/sys_arr_pkg.sv
// Shared systolic-array types: register-file geometry, writeback request record
// and the writeback grant encoding.
package sys_arr_pkg;

    localparam int DATA_W     = 512;
    localparam int REG_ADDR_W = 8;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] wbdst;
        logic [DATA_W-1:0]     data;
    } wb_req_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_GSAU = 2'd1,
        GNT_VU   = 2'd2
    } grant_t;

endpackage

// File: rtl/gsau_wb_arbiter_if.sv
// Bundle of GSAU/VU writeback requests, register-file write port and scoreboard
// completion seen by the writeback arbiter.
interface gsau_wb_arbiter_if #(
    parameter int DEPTH = 4
) ();
    import sys_arr_pkg::*;

    logic                    gsau_valid;
    logic [REG_ADDR_W-1:0]   gsau_wbdst;
    logic [DATA_W-1:0]       gsau_data;
    logic                    gsau_ready;

    logic                    vu_valid;
    logic [REG_ADDR_W-1:0]   vu_wbdst;
    logic [DATA_W-1:0]       vu_data;
    logic                    vu_ready;

    logic                    rf_wen;
    logic [REG_ADDR_W-1:0]   rf_waddr;
    logic [DATA_W-1:0]       rf_wdata;
    logic                    rf_stall;

    logic                    sb_done;
    logic [REG_ADDR_W-1:0]   sb_done_dst;

    logic [$clog2(DEPTH):0]  fifo_count;

    modport slave (
        input  gsau_valid, gsau_wbdst, gsau_data,
        output gsau_ready,
        input  vu_valid, vu_wbdst, vu_data,
        output vu_ready,
        output rf_wen, rf_waddr, rf_wdata,
        input  rf_stall,
        output sb_done, sb_done_dst,
        output fifo_count
    );

    modport master (
        output gsau_valid, gsau_wbdst, gsau_data,
        input  gsau_ready,
        output vu_valid, vu_wbdst, vu_data,
        input  vu_ready,
        input  rf_wen, rf_waddr, rf_wdata,
        output rf_stall,
        input  sb_done, sb_done_dst,
        input  fifo_count
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous active-low reset; pointers carry one extra
// wrap bit so full and empty are distinguishable without a separate flag.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign rdata   = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset: entries are only visible between the pointers.
    always_ff @(posedge CLK) begin
        if (nRST && do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/gsau_wb_arbiter.sv
// Arbitrates the single register-file write port between buffered GSAU results
// and unbuffered vector-unit writebacks, with a starvation bound for the GSAU.
module gsau_wb_arbiter
    import sys_arr_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 4
) (
    input  logic            CLK,
    input  logic            nRST,
    gsau_wb_arbiter_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    wb_req_t         push_req;
    wb_req_t         head;
    logic [CW-1:0]   count;
    logic            empty;
    logic            push;
    logic            pop;
    grant_t          grant;
    logic [SW-1:0]   starve_cnt;

    assign push_req       = {bus.gsau_wbdst, bus.gsau_data};
    assign bus.gsau_ready = nRST && (count < FULL_CNT);
    assign push           = bus.gsau_valid && bus.gsau_ready;
    assign pop            = (grant == GNT_GSAU);
    assign bus.vu_ready   = (grant == GNT_VU);
    assign bus.fifo_count = count;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(wb_req_t))
    ) u_fifo (
        .CLK   (CLK),
        .nRST  (nRST),
        .push  (push),
        .wdata (push_req),
        .pop   (pop),
        .rdata (head),
        .count (count),
        .empty (empty)
    );

    always_comb begin
        grant = GNT_NONE;
        if (nRST && !bus.rf_stall) begin
            if (!empty && (!bus.vu_valid || starve_cnt == STARVE_LIM))
                grant = GNT_GSAU;
            else if (bus.vu_valid)
                grant = GNT_VU;
        end
    end

    // Stalled cycles neither age nor forgive the GSAU; only real VU wins count.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            starve_cnt <= '0;
        end else if (empty || grant == GNT_GSAU) begin
            starve_cnt <= '0;
        end else if (grant == GNT_VU && starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            bus.rf_wen      <= 1'b0;
            bus.rf_waddr    <= '0;
            bus.rf_wdata    <= '0;
            bus.sb_done     <= 1'b0;
            bus.sb_done_dst <= '0;
        end else begin
            case (grant)
                GNT_GSAU: begin
                    bus.rf_wen      <= 1'b1;
                    bus.rf_waddr    <= head.wbdst;
                    bus.rf_wdata    <= head.data;
                    bus.sb_done     <= 1'b1;
                    bus.sb_done_dst <= head.wbdst;
                end
                GNT_VU: begin
                    bus.rf_wen      <= 1'b1;
                    bus.rf_waddr    <= bus.vu_wbdst;
                    bus.rf_wdata    <= bus.vu_data;
                    bus.sb_done     <= 1'b0;
                end
                default: begin
                    bus.rf_wen      <= 1'b0;
                    bus.sb_done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gsau_wb_arbiter.sv
// Self-checking bench for gsau_wb_arbiter: directed scenarios plus a randomized
// ordering run against a queue-based reference model.
module tb_gsau_wb_arbiter;
    import sys_arr_pkg::*;

    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 4;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    gsau_wb_arbiter_if #(.DEPTH(DEPTH)) bus ();

    gsau_wb_arbiter #(
        .DEPTH      (DEPTH),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    wb_req_t      mq[$];
    int           mstarve = 0;
    logic         exp_wen, exp_done, exp_gready, exp_vready;
    logic [7:0]   exp_waddr, exp_dst;
    logic [511:0] exp_wdata;
    logic         obs_gready, obs_vready;
    logic [$clog2(DEPTH):0] obs_count;

    // Apply inputs, sample combinational outputs, advance model, clock one edge.
    task automatic drive_cycle(input logic rst_n, input logic gv, input logic [7:0] gdst,
                               input logic [511:0] gdata, input logic vv, input logic [7:0] vdst,
                               input logic [511:0] vdata, input logic stall);
        wb_req_t h;
        wb_req_t nr;
        int g;
        nRST           = rst_n;
        bus.gsau_valid = gv;
        bus.gsau_wbdst = gdst;
        bus.gsau_data  = gdata;
        bus.vu_valid   = vv;
        bus.vu_wbdst   = vdst;
        bus.vu_data    = vdata;
        bus.rf_stall   = stall;
        #1;
        obs_gready = bus.gsau_ready;
        obs_vready = bus.vu_ready;
        obs_count  = bus.fifo_count;

        exp_gready = rst_n && (mq.size() < DEPTH);
        g = 0;
        if (rst_n && !stall) begin
            if (mq.size() > 0 && (!vv || mstarve == STARVE_MAX)) g = 1;
            else if (vv) g = 2;
        end
        exp_vready = (g == 2);
        if (!rst_n) begin
            mq.delete();
            mstarve   = 0;
            exp_wen   = 0;
            exp_done  = 0;
            exp_waddr = 0;
            exp_wdata = 0;
            exp_dst   = 0;
        end else begin
            if (mq.size() == 0 || g == 1) mstarve = 0;
            else if (g == 2 && mstarve < STARVE_MAX) mstarve++;
            exp_wen  = (g != 0);
            exp_done = (g == 1);
            if (g == 1) begin
                h = mq.pop_front();
                exp_waddr = h.wbdst;
                exp_wdata = h.data;
                exp_dst   = h.wbdst;
            end else if (g == 2) begin
                exp_waddr = vdst;
                exp_wdata = vdata;
            end
            if (gv && exp_gready) begin
                nr.wbdst = gdst;
                nr.data  = gdata;
                mq.push_back(nr);
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input logic stall);
        drive_cycle(1'b1, 1'b0, 8'h00, '0, 1'b0, 8'h00, '0, stall);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1'b0, 1'b1, 8'h11, {16{32'h5A5A5A5A}}, 1'b1, 8'h22, '1, 1'b0);
            checks++;
            if (obs_gready !== 1'b0 || obs_vready !== 1'b0) begin
                errors++;
                $display("FAIL reset_ready: gsau_ready=%b vu_ready=%b, want 0 0", obs_gready, obs_vready);
            end
        end
        checks++;
        if (bus.rf_wen !== 1'b0 || bus.sb_done !== 1'b0 || bus.fifo_count !== '0) begin
            errors++;
            $display("FAIL reset_ctl: rf_wen=%b sb_done=%b count=%0d, want 0 0 0",
                     bus.rf_wen, bus.sb_done, bus.fifo_count);
        end
        checks++;
        if (bus.rf_waddr !== 8'h00 || bus.rf_wdata !== '0 || bus.sb_done_dst !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: waddr=%h dst=%h, want 00 00", bus.rf_waddr, bus.sb_done_dst);
        end
    endtask

    task automatic test_idle_path();
        drive_cycle(1'b1, 1'b1, 8'h42, 512'hCAFEBABE, 1'b0, 8'h00, '0, 1'b0);
        checks++;
        if (bus.rf_wen !== 1'b0 || bus.fifo_count !== 3'd1) begin
            errors++;
            $display("FAIL idle_k: rf_wen=%b count=%0d, want 0 1", bus.rf_wen, bus.fifo_count);
        end
        idle(1'b0);
        checks++;
        if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== 8'h42 || bus.rf_wdata !== 512'hCAFEBABE ||
            bus.sb_done !== 1'b1 || bus.sb_done_dst !== 8'h42) begin
            errors++;
            $display("FAIL idle_write: wen=%b waddr=%h wdata=%h done=%b dst=%h, want 1 42 cafebabe 1 42",
                     bus.rf_wen, bus.rf_waddr, bus.rf_wdata[31:0], bus.sb_done, bus.sb_done_dst);
        end
        idle(1'b0);
        checks++;
        if (bus.rf_wen !== 1'b0 || bus.sb_done !== 1'b0 || bus.rf_waddr !== 8'h42) begin
            errors++;
            $display("FAIL idle_after: wen=%b done=%b waddr=%h, want 0 0 42",
                     bus.rf_wen, bus.sb_done, bus.rf_waddr);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            drive_cycle(1'b1, 1'b1, 8'(i), 512'(i + 100), 1'b1, 8'hA0, '0, 1'b1);
            checks++;
            if (obs_gready !== 1'b1 || obs_vready !== 1'b0) begin
                errors++;
                $display("FAIL fill_push%0d: gsau_ready=%b vu_ready=%b, want 1 0", i, obs_gready, obs_vready);
            end
        end
        checks++;
        if (bus.fifo_count !== 3'd4) begin
            errors++;
            $display("FAIL fill_count: count=%0d want 4", bus.fifo_count);
        end
        drive_cycle(1'b1, 1'b1, 8'hFF, '1, 1'b1, 8'hA0, '0, 1'b1);
        checks++;
        if (obs_gready !== 1'b0 || bus.fifo_count !== 3'd4) begin
            errors++;
            $display("FAIL fill_full: gsau_ready=%b count=%0d, want 0 4", obs_gready, bus.fifo_count);
        end
        for (int i = 0; i < DEPTH; i++) begin
            idle(1'b0);
            checks++;
            if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== 8'(i) || bus.sb_done !== 1'b1 ||
                bus.rf_wdata !== 512'(i + 100)) begin
                errors++;
                $display("FAIL fill_drain%0d: wen=%b waddr=%h done=%b, want 1 %h 1",
                         i, bus.rf_wen, bus.rf_waddr, bus.sb_done, 8'(i));
            end
        end
        idle(1'b0);
        checks++;
        if (bus.rf_wen !== 1'b0 || bus.fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL fill_empty: wen=%b count=%0d, want 0 0", bus.rf_wen, bus.fifo_count);
        end
    endtask

    task automatic test_starvation();
        logic [7:0] want;
        logic       want_done;
        drive_cycle(1'b1, 1'b1, 8'h10, 512'hD00D, 1'b0, 8'h00, '0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b1, 1'b0, 8'h00, '0, 1'b1, 8'(8'h80 + i), 512'(i), 1'b0);
            want      = (i == 4) ? 8'h10 : 8'(8'h80 + i);
            want_done = (i == 4);
            checks++;
            if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== want || bus.sb_done !== want_done ||
                obs_vready !== !want_done) begin
                errors++;
                $display("FAIL starve%0d: wen=%b waddr=%h done=%b vu_ready=%b, want 1 %h %b %b",
                         i, bus.rf_wen, bus.rf_waddr, bus.sb_done, obs_vready, want, want_done, !want_done);
            end
        end
        idle(1'b0);
    endtask

    task automatic test_stall();
        drive_cycle(1'b1, 1'b1, 8'h20, 512'hBEEF, 1'b0, 8'h00, '0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, 1'b0, 8'h00, '0, 1'b1, 8'h90, '0, 1'b1);
            checks++;
            if (bus.rf_wen !== 1'b0 || obs_vready !== 1'b0 || bus.fifo_count !== 3'd1) begin
                errors++;
                $display("FAIL stall%0d: wen=%b vu_ready=%b count=%0d, want 0 0 1",
                         i, bus.rf_wen, obs_vready, bus.fifo_count);
            end
        end
        drive_cycle(1'b1, 1'b0, 8'h00, '0, 1'b1, 8'h91, 512'h91, 1'b0);
        checks++;
        if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== 8'h91 || bus.sb_done !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: wen=%b waddr=%h done=%b, want 1 91 0",
                     bus.rf_wen, bus.rf_waddr, bus.sb_done);
        end
        idle(1'b0);
        checks++;
        if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== 8'h20 || bus.sb_done !== 1'b1) begin
            errors++;
            $display("FAIL stall_gsau: wen=%b waddr=%h done=%b, want 1 20 1",
                     bus.rf_wen, bus.rf_waddr, bus.sb_done);
        end
        idle(1'b0);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++)
            drive_cycle(1'b1, 1'b1, 8'(8'h60 + i), 512'(i), 1'b0, 8'h00, '0, 1'b1);
        checks++;
        if (bus.fifo_count !== 3'd3) begin
            errors++;
            $display("FAIL rstmid_fill: count=%0d want 3", bus.fifo_count);
        end
        drive_cycle(1'b0, 1'b0, 8'h00, '0, 1'b0, 8'h00, '0, 1'b0);
        checks++;
        if (bus.fifo_count !== 3'd0 || bus.rf_wen !== 1'b0) begin
            errors++;
            $display("FAIL rstmid: count=%0d wen=%b, want 0 0", bus.fifo_count, bus.rf_wen);
        end
        for (int i = 0; i < 5; i++) begin
            idle(1'b0);
            checks++;
            if (bus.rf_wen !== 1'b0 || bus.sb_done !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_after%0d: wen=%b done=%b, want 0 0", i, bus.rf_wen, bus.sb_done);
            end
        end
    endtask

    task automatic test_random_order();
        logic [7:0] pushed[$];
        logic [7:0] got[$];
        int         npush = 0;
        int         cyc   = 0;
        logic       gv, vv, st;
        logic [7:0] dst;
        while (npush < 20 && cyc < 600) begin
            gv  = $urandom_range(0, 1);
            vv  = $urandom_range(0, 1);
            st  = ($urandom_range(0, 2) == 0);
            dst = 8'(8'h30 + npush);
            drive_cycle(1'b1, gv, dst, {16{$urandom}}, vv, 8'($urandom_range(0, 255)), {16{$urandom}}, st);
            if (gv && exp_gready) begin
                pushed.push_back(dst);
                npush++;
            end
            if (bus.sb_done === 1'b1) got.push_back(bus.sb_done_dst);
            cyc++;
            checks++;
            if (obs_gready !== exp_gready || obs_vready !== exp_vready ||
                bus.rf_wen !== exp_wen || bus.sb_done !== exp_done ||
                bus.fifo_count !== 3'(mq.size())) begin
                errors++;
                $display("FAIL rand_ctl@%0d: gr=%b vr=%b wen=%b done=%b cnt=%0d, want %b %b %b %b %0d",
                         cyc, obs_gready, obs_vready, bus.rf_wen, bus.sb_done, bus.fifo_count,
                         exp_gready, exp_vready, exp_wen, exp_done, mq.size());
            end
            if (exp_wen) begin
                checks++;
                if (bus.rf_waddr !== exp_waddr || bus.rf_wdata !== exp_wdata ||
                    (exp_done && bus.sb_done_dst !== exp_dst)) begin
                    errors++;
                    $display("FAIL rand_data@%0d: waddr=%h dst=%h, want %h %h",
                             cyc, bus.rf_waddr, bus.sb_done_dst, exp_waddr, exp_dst);
                end
            end
        end
        checks++;
        if (npush < 20) begin
            errors++;
            $display("FAIL rand_budget: pushes=%0d want 20", npush);
        end
        for (int i = 0; i < 20 && (mq.size() > 0 || bus.rf_wen === 1'b1); i++) begin
            idle(1'b0);
            if (bus.sb_done === 1'b1) got.push_back(bus.sb_done_dst);
        end
        checks++;
        if (got.size() != pushed.size()) begin
            errors++;
            $display("FAIL rand_count: writes=%0d want %0d", got.size(), pushed.size());
        end else begin
            foreach (pushed[i]) begin
                checks++;
                if (got[i] !== pushed[i]) begin
                    errors++;
                    $display("FAIL rand_order[%0d]: dst=%h want %h", i, got[i], pushed[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_path();
        test_fill();
        test_starvation();
        test_stall();
        test_reset_mid();
        test_random_order();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
